// File: rtl/mult_div_unit.sv
// Iterative multiply / restoring divide into HI/LO; optional signed mode under MULT_DIV_SIGNED_EN.
// Latency: done pulses WIDTH+1 edges after the accepting edge (divide-by-zero: 1 edge).
// Backpressure: start is sampled only in IDLE; start while busy is dropped, never queued.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_nxt;
   logic [2*WIDTH:0]   acc;        // {upper WIDTH+1 bits, lower WIDTH bits}
   logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
   logic               op_r;
   logic               zero_r;     // current op is a divide by zero: FIX only pulses done
   logic [CW-1:0]      count;

   logic               b_is_zero;
   logic               last_iter;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH:0]   mul_step;
   logic [2*WIDTH:0]   shifted;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH:0]   div_step;

   assign b_is_zero = (b == '0);
   assign last_iter = (count == CW'(WIDTH - 1));

   // one shift-add / restoring-divide iteration on the working accumulator
   always_comb begin
      add_sum  = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
      mul_step = acc[0] ? ({add_sum, acc[WIDTH-1:0]} >> 1) : (acc >> 1);
      shifted  = {acc[2*WIDTH-1:0], 1'b0};
      diff     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, opnd};
      div_step = diff[WIDTH+1] ? shifted : {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
   end

`ifdef MULT_DIV_SIGNED_EN
   logic neg_res_r;   // product / quotient must be negated
   logic neg_rem_r;   // remainder takes the dividend's (negative) sign

   // magnitudes on entry, sign correction on exit
   always_comb begin
      a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
      if (!op_r) begin
         {fix_hi, fix_lo} = neg_res_r ? (~acc[2*WIDTH-1:0] + 1'b1) : acc[2*WIDTH-1:0];
      end else begin
         fix_lo = neg_res_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
         fix_hi = neg_rem_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      end
   end

   // sign flags captured with the operands
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
      end else if (state == IDLE && start) begin
         neg_res_r <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_rem_r <= signed_op & a[WIDTH-1];
      end
   end
`else
   logic unused_signed_op;
   assign unused_signed_op = signed_op;

   // unsigned only: operands and results pass straight through
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
   end
`endif

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: divide by zero skips RUN and goes straight to the done cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (op && b_is_zero) ? FIX : RUN;
         RUN:     if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath, result registers and handshake outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         opnd     <= '0;
         op_r     <= 1'b0;
         zero_r   <= 1'b0;
         count    <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_r     <= op;
                  count    <= '0;
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  if (op && b_is_zero) begin
                     hi       <= a;
                     lo       <= '1;
                     div_zero <= 1'b1;
                     zero_r   <= 1'b1;
                  end else begin
                     zero_r <= 1'b0;
                     opnd   <= op ? b_mag : a_mag;
                     acc    <= {{(WIDTH+1){1'b0}}, (op ? a_mag : b_mag)};
                  end
               end
            end
            RUN: begin
               acc   <= op_r ? div_step : mul_step;
               count <= count + 1'b1;
            end
            FIX: begin
               busy <= 1'b0;
               done <= 1'b1;
               if (!zero_r) begin
                  hi <= fix_hi;
                  lo <= fix_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
